// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding and pending-call search helpers for elevator_ctrl.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } state_e;

    // Widest floor count the search helpers cover; callers zero-extend into this width.
    localparam int unsigned MAX_FLOORS = 32;

    // True when any call is latched strictly above the given floor.
    function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                       input int unsigned floor);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (i > floor && pend[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    // True when any call is latched strictly below the given floor.
    function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                       input int unsigned floor);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
            if (i < floor && pend[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/elev_cycle_timer.sv
// elev_cycle_timer: loadable down-counter, saturates at zero, done flags a zero count.
module elev_cycle_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    // Load has priority over decrement; decrement stops at zero.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (dec && count != '0) begin
            count_next = count - WIDTH'(1);
        end
    end

    // Count register with registered zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            done  <= 1'b1;
        end else begin
            count <= count_next;
            done  <= (count_next == '0);
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: N-floor SCAN elevator controller with cycle-timed travel and door dwell.
// Optional emergency stop (estop port and freeze logic) built when ELEV_ESTOP_EN is defined.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter  int unsigned NUM_FLOORS  = 4,
    parameter  int unsigned MOVE_CYCLES = 4,
    parameter  int unsigned DOOR_CYCLES = 3,
    localparam int unsigned FLOOR_W     = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req_mask,
`ifdef ELEV_ESTOP_EN
    input  logic                  estop,
`endif
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int unsigned TIMER_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);

    state_e                  state;
    state_e                  state_next;
    logic [FLOOR_W-1:0]      floor_next;
    logic                    dir_next;
    logic                    t_load;
    logic [TIMER_W-1:0]      t_val;
    logic                    t_dec;
    logic                    t_done;
    logic                    eval;
    logic                    eval_hit;
    logic [FLOOR_W-1:0]      eval_floor;
    logic                    above;
    logic                    below;
    logic [NUM_FLOORS-1:0]   clear_mask;
    logic [NUM_FLOORS-1:0]   hold_mask;
    logic [NUM_FLOORS-1:0]   pending_next;
    logic                    freeze;
    logic                    estop_now;

`ifdef ELEV_ESTOP_EN
    logic halted;

    // Registered estop so the freeze and the moving output drop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) halted <= 1'b0;
        else     halted <= estop;
    end

    assign freeze    = halted;
    assign estop_now = estop;
`else
    assign freeze    = 1'b0;
    assign estop_now = 1'b0;
`endif

    // Shared move/door dwell timer.
    elev_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .done     (t_done)
    );

    // Next-state, floor step, SCAN decision and pending-call update.
    always_comb begin
        state_next = state;
        floor_next = cur_floor;
        dir_next   = dir_up;
        t_load     = 1'b0;
        t_val      = '0;
        t_dec      = 1'b0;
        eval       = 1'b0;
        eval_hit   = 1'b0;
        eval_floor = cur_floor;
        clear_mask = '0;
        hold_mask  = '0;

        if (!freeze) begin
            case (state)
                ST_IDLE: begin
                    eval     = 1'b1;
                    eval_hit = pending[cur_floor];
                end
                ST_MOVING: begin
                    if (t_done) begin
                        floor_next = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
                        eval       = 1'b1;
                        eval_floor = floor_next;
                        eval_hit   = pending[floor_next] | req_mask[floor_next];
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                ST_DOOR: begin
                    if (req_mask[cur_floor]) begin
                        t_load = 1'b1;
                        t_val  = TIMER_W'(DOOR_CYCLES - 1);
                    end else if (t_done) begin
                        eval     = 1'b1;
                        eval_hit = pending[cur_floor];
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        above = any_above(MAX_FLOORS'(pending), 32'(eval_floor));
        below = any_below(MAX_FLOORS'(pending), 32'(eval_floor));

        if (eval) begin
            if (eval_hit) begin
                state_next = ST_DOOR;
                t_load     = 1'b1;
                t_val      = TIMER_W'(DOOR_CYCLES - 1);
            end else if (dir_up ? above : below) begin
                state_next = ST_MOVING;
                t_load     = 1'b1;
                t_val      = TIMER_W'(MOVE_CYCLES - 1);
            end else if (dir_up ? below : above) begin
                state_next = ST_MOVING;
                dir_next   = ~dir_up;
                t_load     = 1'b1;
                t_val      = TIMER_W'(MOVE_CYCLES - 1);
            end else begin
                state_next = ST_IDLE;
            end
        end

        if (!freeze && state_next == ST_DOOR) begin
            clear_mask = NUM_FLOORS'(1) << floor_next;
        end
        if (state == ST_DOOR) begin
            hold_mask = NUM_FLOORS'(1) << cur_floor;
        end
        pending_next = (pending | (req_mask & ~hold_mask)) & ~clear_mask;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Registered outputs: position, direction, calls and actuator commands.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_floor <= '0;
            dir_up    <= 1'b1;
            pending   <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
        end else begin
            cur_floor <= floor_next;
            dir_up    <= dir_next;
            pending   <= pending_next;
            moving    <= (state_next == ST_MOVING) && !estop_now;
            door_open <= (state_next == ST_DOOR);
        end
    end

endmodule
